// File: rtl/i2s_pkg.sv
// Shared constants, output-format selection and counter sizing for the I2S transmit path.
// I2S_TX_LJ_EN selects left-justified output; undefined gives standard one-slot-delayed I2S.
package i2s_pkg;

  localparam int SLOTS_PER_CH = 32;

  typedef enum logic [0:0] {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_e;

`ifdef I2S_TX_LJ_EN
  localparam fmt_e TX_FMT = FMT_LJ;
`else
  localparam fmt_e TX_FMT = FMT_I2S;
`endif

  // One frame is two channels of SLOTS_PER_CH slots, each slot one SCK period.
  function automatic int cnt_width(input int mclk_half, input int sck_per_mclk);
    return $clog2(2 * mclk_half * sck_per_mclk * 2 * SLOTS_PER_CH);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running frame counter producing registered MCLK/SCK/LRCK plus look-ahead
// strobes that tell the scheduler what the counter becomes on the next edge.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int MCLK_HALF    = 4,
  parameter int SCK_PER_MCLK = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mclk,
  output logic       sck,
  output logic       lrck,
  output logic       slot_edge,
  output logic       load_edge,
  output logic [4:0] slot_nxt,
  output logic       ch_nxt
);

  localparam int CW = cnt_width(MCLK_HALF, SCK_PER_MCLK);
  localparam int P  = 2 * MCLK_HALF * SCK_PER_MCLK;
  localparam int PW = $clog2(P);
  localparam int MW = $clog2(MCLK_HALF);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] ahead;

  assign cnt_nxt = cnt_r + {{(CW-1){1'b0}}, 1'b1};
  // ahead is the count one edge beyond cnt_nxt; strobes built from it are valid
  // in the cycle just before the edge they describe.
  assign ahead   = cnt_r + {{(CW-2){1'b0}}, 2'b10};

  // Counter and registered clock outputs; everything reflects the value cnt takes at this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {CW{1'b0}};
      mclk      <= 1'b0;
      sck       <= 1'b0;
      lrck      <= 1'b0;
      slot_edge <= 1'b0;
      load_edge <= 1'b0;
      slot_nxt  <= 5'd0;
      ch_nxt    <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt;
      mclk      <= cnt_nxt[MW];
      sck       <= cnt_nxt[PW-1];
      lrck      <= cnt_nxt[CW-1];
      slot_edge <= (ahead[PW-1:0] == {PW{1'b0}});
      load_edge <= (ahead == {CW{1'b1}});
      slot_nxt  <= ahead[CW-2:PW];
      ch_nxt    <= ahead[CW-1];
    end
  end

endmodule

// File: rtl/i2s_tx_sched.sv
// I2S frame scheduler: sample hold register with valid/ready intake, per-frame load
// with underrun counting, and slot serialiser. Format follows I2S_TX_LJ_EN via i2s_pkg.
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter int MCLK_HALF    = 4,
  parameter int SCK_PER_MCLK = 4,
  parameter int WIDTH        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] smp_l,
  input  logic [WIDTH-1:0] smp_r,
  input  logic             smp_valid,
  output logic             smp_ready,
  output logic             mclk,
  output logic             sck,
  output logic             lrck,
  output logic             sdout,
  output logic             underrun,
  output logic [15:0]      under_cnt
);

  logic             slot_edge;
  logic             load_edge;
  logic [4:0]       slot_nxt;
  logic             ch_nxt;

  logic [WIDTH-1:0] hold_l_r, hold_r_r, word_l_r, word_r_r;
  logic [WIDTH-1:0] hold_l_nxt, hold_r_nxt, word_l_nxt, word_r_nxt;
  logic             hold_full_r, hold_full_nxt;
  logic [15:0]      under_nxt;
  logic             underrun_nxt;
  logic             sdout_nxt;
  logic             hs;

  i2s_clkgen #(
    .MCLK_HALF   (MCLK_HALF),
    .SCK_PER_MCLK(SCK_PER_MCLK)
  ) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .mclk     (mclk),
    .sck      (sck),
    .lrck     (lrck),
    .slot_edge(slot_edge),
    .load_edge(load_edge),
    .slot_nxt (slot_nxt),
    .ch_nxt   (ch_nxt)
  );

  // Bit of word w carried by slot s; shifting the wanted bit to the MSB avoids a wide index.
  function automatic logic slot_bit(input logic [WIDTH-1:0] w, input logic [4:0] s);
    int               si;
    logic [WIDTH-1:0] sh;
    logic             b;
    si = int'(s);
    sh = {WIDTH{1'b0}};
    b  = 1'b0;
    case (TX_FMT)
      FMT_LJ: begin
        if (si < WIDTH) begin
          sh = w << si;
          b  = sh[WIDTH-1];
        end else begin
          b = 1'b0;
        end
      end
      FMT_I2S: begin
        if ((si >= 1) && (si <= WIDTH)) begin
          sh = w << (si - 1);
          b  = sh[WIDTH-1];
        end else begin
          b = 1'b0;
        end
      end
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // Next-state for hold register, frame words, underrun accounting and serial data.
  always_comb begin
    hs            = smp_valid && smp_ready;
    hold_l_nxt    = hold_l_r;
    hold_r_nxt    = hold_r_r;
    hold_full_nxt = hold_full_r;
    word_l_nxt    = word_l_r;
    word_r_nxt    = word_r_r;
    under_nxt     = under_cnt;
    underrun_nxt  = 1'b0;
    sdout_nxt     = sdout;

    if (load_edge) begin
      if (hold_full_r) begin
        word_l_nxt    = hold_l_r;
        word_r_nxt    = hold_r_r;
        hold_full_nxt = 1'b0;
      end else begin
        word_l_nxt   = {WIDTH{1'b0}};
        word_r_nxt   = {WIDTH{1'b0}};
        underrun_nxt = 1'b1;
        under_nxt    = (under_cnt == 16'hFFFF) ? under_cnt : under_cnt + 16'd1;
      end
    end else begin
      underrun_nxt = 1'b0;
    end

    // A transfer coinciding with an empty-hold load still fills hold for the next frame.
    if (hs) begin
      hold_l_nxt    = smp_l;
      hold_r_nxt    = smp_r;
      hold_full_nxt = 1'b1;
    end else begin
      hold_l_nxt = hold_l_r;
      hold_r_nxt = hold_r_r;
    end

    if (slot_edge) begin
      sdout_nxt = slot_bit(ch_nxt ? word_r_r : word_l_r, slot_nxt);
    end else begin
      sdout_nxt = sdout;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l_r    <= {WIDTH{1'b0}};
      hold_r_r    <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
      word_l_r    <= {WIDTH{1'b0}};
      word_r_r    <= {WIDTH{1'b0}};
      smp_ready   <= 1'b1;
      underrun    <= 1'b0;
      under_cnt   <= 16'd0;
      sdout       <= 1'b0;
    end else begin
      hold_l_r    <= hold_l_nxt;
      hold_r_r    <= hold_r_nxt;
      hold_full_r <= hold_full_nxt;
      word_l_r    <= word_l_nxt;
      word_r_r    <= word_r_nxt;
      smp_ready   <= !hold_full_nxt;
      underrun    <= underrun_nxt;
      under_cnt   <= under_nxt;
      sdout       <= sdout_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Randomised bench for i2s_tx_sched against a cycle-by-cycle frame model derived from
// the counter arithmetic; honours I2S_TX_LJ_EN for the expected slot format.
module tb_i2s_tx_sched;

  localparam int MH    = 4;
  localparam int SPM   = 4;
  localparam int W     = 16;
  localparam int P     = 2 * MH * SPM;
  localparam int FRAME = 64 * P;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  smp_l, smp_r;
  logic          smp_valid;
  logic          smp_ready, mclk, sck, lrck, sdout, underrun;
  logic [15:0]   under_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: position in frame, hold, pair for next frame, pair now playing
  int            m_cnt;
  bit            m_full, m_ready, m_ur;
  logic [W-1:0]  m_hl, m_hr, m_nl, m_nr, m_pl, m_pr;
  int            m_ucnt;

  i2s_tx_sched #(.MCLK_HALF(MH), .SCK_PER_MCLK(SPM), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .smp_l    (smp_l),
    .smp_r    (smp_r),
    .smp_valid(smp_valid),
    .smp_ready(smp_ready),
    .mclk     (mclk),
    .sck      (sck),
    .lrck     (lrck),
    .sdout    (sdout),
    .underrun (underrun),
    .under_cnt(under_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cnt %0d)", tag, act, exp, m_cnt);
    end
  endtask

  function automatic logic exp_sdout(input int v, input logic [W-1:0] wl, input logic [W-1:0] wr);
    int s;
    int w;
    s = (v / P) % 32;
    w = (v >= FRAME / 2) ? int'(wr) : int'(wl);
`ifdef I2S_TX_LJ_EN
    if (s < W) return logic'((w >> (W - 1 - s)) & 1);
`else
    if (s >= 1 && s <= W) return logic'((w >> (W - s)) & 1);
`endif
    return 1'b0;
  endfunction

  task automatic model_step();
    bit hs;
    if (rst) begin
      m_cnt = 0; m_full = 0; m_ready = 1; m_ur = 0; m_ucnt = 0;
      m_hl = '0; m_hr = '0; m_nl = '0; m_nr = '0; m_pl = '0; m_pr = '0;
    end else begin
      hs    = smp_valid && m_ready;
      m_cnt = (m_cnt + 1) % FRAME;
      m_ur  = 0;
      if (m_cnt == FRAME - 1) begin
        if (m_full) begin
          m_nl = m_hl; m_nr = m_hr; m_full = 0;
        end else begin
          m_nl = '0; m_nr = '0; m_ur = 1;
          if (m_ucnt < 65535) m_ucnt++;
        end
      end
      if (m_cnt == 0) begin
        m_pl = m_nl; m_pr = m_nr;
      end
      if (hs) begin
        m_hl = smp_l; m_hr = smp_r; m_full = 1;
      end
      m_ready = !m_full;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("mclk", 32'(mclk), (m_cnt / MH) % 2);
    check("sck", 32'(sck), (m_cnt / (P / 2)) % 2);
    check("lrck", 32'(lrck), m_cnt / (FRAME / 2));
    check("sdout", 32'(sdout), 32'(exp_sdout(m_cnt, m_pl, m_pr)));
    check("underrun", 32'(underrun), 32'(m_ur));
    check("under_cnt", 32'(under_cnt), m_ucnt);
    check("smp_ready", 32'(smp_ready), 32'(m_ready));
  endtask

  task automatic random_drive();
    smp_valid = ($urandom_range(0, 1499) == 0);
    smp_l     = W'($urandom);
    smp_r     = W'($urandom);
  endtask

  initial begin
    int guard;
    rst = 1'b1; smp_valid = 1'b0; smp_l = '0; smp_r = '0;
    m_cnt = 0;
    repeat (2) cycle();
    rst = 1'b0;

    // two silent frames with no source, then a fixed pattern with valid held high
    repeat (2 * FRAME) cycle();
    check("under_cnt_after_2", 32'(under_cnt), 32'd2);
    smp_l = 16'h8001; smp_r = 16'h7FFE; smp_valid = 1'b1;
    repeat (3 * FRAME) cycle();
    check("no_underrun_frames_2_4", 32'(under_cnt), 32'd2);

    // sporadic random offers
    for (int i = 0; i < 5 * FRAME; i++) begin
      random_drive();
      cycle();
    end

    // handshake on the very edge that loads an empty hold register
    smp_valid = 1'b0;
    guard = 0;
    while (!(m_cnt == FRAME - 2 && !m_full) && guard < 3 * FRAME) begin
      cycle();
      guard++;
    end
    check("reach_load_edge", 32'(guard < 3 * FRAME), 32'd1);
    smp_l = 16'hA5C3; smp_r = 16'h3C5A; smp_valid = 1'b1;
    cycle();
    smp_valid = 1'b0;
    check("hs_load_underrun", 32'(underrun), 32'd1);
    check("hs_load_ready", 32'(smp_ready), 32'd0);
    repeat (FRAME + 2) cycle();
    check("hs_load_ready_back", 32'(smp_ready), 32'd1);

    // saturation of the underrun counter
    force dut.under_cnt = 16'hFFFE;
    #1;
    release dut.under_cnt;
    m_ucnt = 32'hFFFE;
    repeat (4 * FRAME) cycle();
    check("under_cnt_sat", 32'(under_cnt), 32'hFFFF);

    // reset in the middle of a playing frame
    smp_l = 16'h1234; smp_r = 16'hFEDC; smp_valid = 1'b1;
    repeat (FRAME) cycle();
    guard = 0;
    while (m_cnt != 1000 && guard < 2 * FRAME) begin
      cycle();
      guard++;
    end
    check("reach_cnt_1000", 32'(m_cnt), 32'd1000);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_under_cnt", 32'(under_cnt), 32'd0);
    check("rst_ready", 32'(smp_ready), 32'd1);
    smp_valid = 1'b0;
    repeat (FRAME) cycle();
    for (int i = 0; i < FRAME + FRAME / 2; i++) begin
      random_drive();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
